// File: rtl/muldiv_unit_if.sv
// Bus bundle between the EX stage and the multiply/divide unit: operation
// launch, squash, MTHI/MTLO writes, and the HI/LO results with status.
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  flush;
    logic [1:0]            hilo_we;
    logic [DATA_WIDTH-1:0] hilo_wdata;
    logic                  busy;
    logic                  done;
    logic                  div_zero;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b, flush, hilo_we, hilo_wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, flush, hilo_we, hilo_wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in the FIX state.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

    stateT           state;
    logic            busyR, doneR, divZeroR;
    logic [W-1:0]    hiR, loR;
    logic [CW-1:0]   cnt;
    logic            isDiv, divByZero, negQ, negR;
    // operand: multiplicand (MUL) or divisor (DIV); accLo: multiplier or dividend/quotient
    logic [W-1:0]    operand, rawA, accHi, accLo;

    logic            aNeg, bNeg;
    logic [W-1:0]    aMag, bMag;
    logic [W:0]      mulSum, divShift, divTrial;
    logic [2*W-1:0]  prodNeg;
    logic [W-1:0]    quoNeg, remNeg;

    assign aNeg     = bus.op[0] & bus.op_a[W-1];
    assign bNeg     = bus.op[0] & bus.op_b[W-1];
    assign aMag     = aNeg ? -bus.op_a : bus.op_a;
    assign bMag     = bNeg ? -bus.op_b : bus.op_b;
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    assign divShift = {accHi, accLo[W-1]};
    assign divTrial = divShift - {1'b0, operand};
    assign prodNeg  = -{accHi, accLo};
    assign quoNeg   = -accLo;
    assign remNeg   = -accHi;

    assign bus.busy     = busyR;
    assign bus.done     = doneR;
    assign bus.div_zero = divZeroR;
    assign bus.hi       = hiR;
    assign bus.lo       = loR;

    // Control FSM, datapath iteration and HI/LO register updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busyR     <= 1'b0;
            doneR     <= 1'b0;
            divZeroR  <= 1'b0;
            hiR       <= '0;
            loR       <= '0;
            cnt       <= '0;
            isDiv     <= 1'b0;
            divByZero <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            operand   <= '0;
            rawA      <= '0;
            accHi     <= '0;
            accLo     <= '0;
        end else begin
            doneR    <= 1'b0;
            divZeroR <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.hilo_we[1]) hiR <= bus.hilo_wdata;
                    if (bus.hilo_we[0]) loR <= bus.hilo_wdata;
                    if (bus.start && !bus.flush) begin
                        busyR     <= 1'b1;
                        cnt       <= '0;
                        accHi     <= '0;
                        rawA      <= bus.op_a;
                        isDiv     <= bus.op[1];
                        divByZero <= bus.op[1] && (bus.op_b == '0);
                        negQ      <= aNeg ^ bNeg;
                        negR      <= aNeg;
                        if (bus.op[1]) begin
                            operand <= bMag;
                            accLo   <= aMag;
                            state   <= DIV;
                        end else begin
                            operand <= aMag;
                            accLo   <= bMag;
                            state   <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        busyR <= 1'b0;
                    end else begin
                        accHi <= mulSum[W:1];
                        accLo <= {mulSum[0], accLo[W-1:1]};
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) state <= FIX;
                    end
                end
                DIV: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        busyR <= 1'b0;
                    end else begin
                        if (!divTrial[W]) begin
                            accHi <= divTrial[W-1:0];
                            accLo <= {accLo[W-2:0], 1'b1};
                        end else begin
                            accHi <= divShift[W-1:0];
                            accLo <= {accLo[W-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busyR <= 1'b0;
                    if (!bus.flush) begin
                        doneR <= 1'b1;
                        if (isDiv) begin
                            if (divByZero) begin
                                loR      <= '1;
                                hiR      <= rawA;
                                divZeroR <= 1'b1;
                            end else begin
                                loR <= negQ ? quoNeg : accLo;
                                hiR <= negR ? remNeg : accHi;
                            end
                        end else begin
                            {hiR, loR} <= negQ ? prodNeg : {accHi, accLo};
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busyR <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed and random operations checked
// against a plain-arithmetic reference, plus flush, reset and hazard cases.
module tb_muldiv_unit;
    logic        clk;
    logic        reset;
    int          vecs;
    int          errs;
    logic [31:0] hiExp;
    logic [31:0] loExp;

    muldiv_unit_if #(.DATA_WIDTH(32)) bus ();

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic dz);
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] u;
        dz = 1'b0;
        eh = '0;
        el = '0;
        case (op)
            2'd0: begin
                u = {32'b0, a} * {32'b0, b};
                eh = u[63:32];
                el = u[31:0];
            end
            2'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                u = p;
                eh = u[63:32];
                el = u[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    el = '1;
                    eh = a;
                    dz = 1'b1;
                end else if (op == 2'd2) begin
                    el = a / b;
                    eh = a % b;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    u = q;
                    el = u[31:0];
                    u = r;
                    eh = u[31:0];
                end
            end
        endcase
    endfunction

    // Launch at the current negedge (back-to-back if called in a done cycle) and check.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input bit withWr, input logic [31:0] wr);
        logic [31:0] eh;
        logic [31:0] el;
        logic        dz;
        int          k;
        int          busyCyc;
        model(op, a, b, eh, el, dz);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        if (withWr) begin
            bus.hilo_we    = 2'b11;
            bus.hilo_wdata = wr;
            hiExp = wr;
            loExp = wr;
        end
        @(negedge clk);
        bus.start   = 1'b0;
        bus.hilo_we = 2'b00;
        bus.op_a    = $urandom;
        bus.op_b    = $urandom;
        vecs++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL start_state op=%0d busy=%b done=%b required busy=1 done=0", op, bus.busy, bus.done);
        end
        vecs++;
        if (bus.hi !== hiExp || bus.lo !== loExp) begin
            errs++;
            $display("FAIL hold_hilo hi=%h lo=%h required hi=%h lo=%h", bus.hi, bus.lo, hiExp, loExp);
        end
        k = 0;
        busyCyc = 1;
        while (bus.done !== 1'b1 && k < 40) begin
            if (k == poke) begin
                bus.start      = 1'b1;
                bus.op         = ~op;
                bus.op_a       = ~a;
                bus.op_b       = b + 32'd1;
                bus.hilo_we    = 2'b11;
                bus.hilo_wdata = 32'h5A5A0F0F;
            end
            @(negedge clk);
            k++;
            bus.start   = 1'b0;
            bus.hilo_we = 2'b00;
            if (bus.busy === 1'b1) busyCyc++;
            if (k == poke + 1) begin
                vecs++;
                if (bus.hi !== hiExp || bus.lo !== loExp) begin
                    errs++;
                    $display("FAIL busy_write hi=%h lo=%h required hi=%h lo=%h", bus.hi, bus.lo, hiExp, loExp);
                end
            end
        end
        vecs++;
        if (k != 33) begin
            errs++;
            $display("FAIL latency op=%0d a=%h b=%h got %0d cycles required 33", op, a, b, k);
        end
        vecs++;
        if (busyCyc != 33 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL busy_len got %0d busy=%b required 33 busy=0", busyCyc, bus.busy);
        end
        vecs++;
        if (bus.hi !== eh || bus.lo !== el) begin
            errs++;
            $display("FAIL result op=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h", op, a, b, bus.hi, bus.lo, eh, el);
        end
        vecs++;
        if (bus.div_zero !== dz) begin
            errs++;
            $display("FAIL div_zero op=%0d b=%h got %b required %b", op, b, bus.div_zero, dz);
        end
        hiExp = eh;
        loExp = el;
    endtask

    task automatic test_reset();
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errs++;
            $display("FAIL reset busy=%b done=%b dz=%b hi=%h lo=%h required all zero", bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
        end
    endtask

    task automatic test_directed();
        do_op(2'd1, 32'hFFFFFFFD, 32'd7, -1, 1'b0, 32'd0);
        vecs++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin
            errs++;
            $display("FAIL mult_m3x7 hi=%h lo=%h required hi=ffffffff lo=ffffffeb", bus.hi, bus.lo);
        end
        do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0, 32'd0);
        vecs++;
        if (bus.hi !== 32'hFFFFFFFE || bus.lo !== 32'h00000001) begin
            errs++;
            $display("FAIL multu_max hi=%h lo=%h required hi=fffffffe lo=00000001", bus.hi, bus.lo);
        end
        do_op(2'd3, 32'hFFFFFFF9, 32'd2, -1, 1'b0, 32'd0);
        vecs++;
        if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFD) begin
            errs++;
            $display("FAIL div_m7_2 hi=%h lo=%h required hi=ffffffff lo=fffffffd", bus.hi, bus.lo);
        end
        do_op(2'd3, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0, 32'd0);
        do_op(2'd2, 32'h00001234, 32'd0, -1, 1'b0, 32'd0);
        @(negedge clk);
        vecs++;
        if (bus.done !== 1'b0 || bus.div_zero !== 1'b0) begin
            errs++;
            $display("FAIL done_pulse done=%b dz=%b required 0 0", bus.done, bus.div_zero);
        end
    endtask

    task automatic test_flush();
        logic seen;
        bus.hilo_we    = 2'b01;
        bus.hilo_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.hilo_we = 2'b00;
        loExp = 32'hA5A5A5A5;
        vecs++;
        if (bus.lo !== loExp) begin
            errs++;
            $display("FAIL mtlo lo=%h required %h", bus.lo, loExp);
        end
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.op_a  = 32'd5;
        bus.op_b  = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lo !== loExp || bus.hi !== hiExp) begin
            errs++;
            $display("FAIL flush busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", bus.busy, bus.done, bus.hi, bus.lo, hiExp, loExp);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        vecs++;
        if (seen !== 1'b0) begin
            errs++;
            $display("FAIL flush_quiet activity=%b required 0", seen);
        end
        do_op(2'd0, 32'd3, 32'd4, -1, 1'b0, 32'd0);
        do_op(2'd2, 32'd100, 32'd7, -1, 1'b0, 32'd0);
        vecs++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            errs++;
            $display("FAIL divu_100_7 hi=%h lo=%h required hi=2 lo=14", bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush_fix();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (32) @(negedge clk);
        vecs++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errs++;
            $display("FAIL pre_fix busy=%b done=%b required 1 0", bus.busy, bus.done);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== hiExp || bus.lo !== loExp) begin
            errs++;
            $display("FAIL flush_fix busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", bus.busy, bus.done, bus.hi, bus.lo, hiExp, loExp);
        end
    endtask

    task automatic test_flush_start();
        bus.start      = 1'b1;
        bus.flush      = 1'b1;
        bus.op         = 2'd2;
        bus.op_a       = 32'd50;
        bus.op_b       = 32'd3;
        bus.hilo_we    = 2'b10;
        bus.hilo_wdata = 32'h13579BDF;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.hilo_we = 2'b00;
        hiExp = 32'h13579BDF;
        vecs++;
        if (bus.busy !== 1'b0 || bus.hi !== hiExp || bus.lo !== loExp) begin
            errs++;
            $display("FAIL flush_start busy=%b hi=%h lo=%h required 0 %h %h", bus.busy, bus.hi, bus.lo, hiExp, loExp);
        end
    endtask

    task automatic test_back_to_back();
        do_op(2'd0, 32'h00012345, 32'h00000789, 5, 1'b0, 32'd0);
        do_op(2'd2, 32'd1000, 32'd33, -1, 1'b1, 32'hDEADBEEF);
        do_op(2'd1, 32'h7FFFFFFF, 32'h80000000, 12, 1'b0, 32'd0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin
                    a = 32'h80000000;
                    b = 32'hFFFFFFFF;
                end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            do_op(op, a, b, -1, 1'b0, 32'd0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd3;
        bus.op_a  = 32'hFFFFFF9C;
        bus.op_b  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errs++;
            $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h required all zero", bus.busy, bus.done, bus.hi, bus.lo);
        end
        reset = 1'b0;
        hiExp = 32'd0;
        loExp = 32'd0;
        repeat (40) @(negedge clk);
        vecs++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.lo !== 32'd0) begin
            errs++;
            $display("FAIL reset_mid_quiet busy=%b done=%b lo=%h required 0 0 0", bus.busy, bus.done, bus.lo);
        end
    endtask

    // Test sequence.
    initial begin
        vecs           = 0;
        errs           = 0;
        hiExp          = 32'd0;
        loExp          = 32'd0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.op         = 2'd0;
        bus.op_a       = 32'd0;
        bus.op_b       = 32'd0;
        bus.flush      = 1'b0;
        bus.hilo_we    = 2'b00;
        bus.hilo_wdata = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_directed();
        test_flush();
        test_flush_fix();
        test_flush_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
